// File: rtl/px_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : px_ram_pkg
// Description : Shared constants for the byte-enabled single-port RAM:
//               read-during-write mode encodings and init FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package px_ram_pkg;

    // Read-during-write behaviour selected by the RAM's RDW_MODE parameter
    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_READ_FIRST  = 2;

    // Init sweep FSM encoding
    localparam int         STATE_W = 1;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

endpackage : px_ram_pkg
`default_nettype wire

// File: rtl/px_ram_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : px_ram_init_fsm
// Description : Post-reset clearing sweep. Walks every word address once,
//               one per cycle, then parks in IDLE and reports init_done.
// Revision    : 1.0 - initial release
// ============================================================================
module px_ram_init_fsm
    import px_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_addr_o,
    output logic                  init_done_o
);

    logic [STATE_W-1:0]    state_q;
    logic [STATE_W-1:0]    state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    // Next state: step the sweep address, leave INIT after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and sweep counter; reset always restarts the sweep at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_we_o   = (state_q == ST_INIT);
    assign init_addr_o = cnt_q;
    assign init_done_o = (state_q == ST_IDLE);

endmodule : px_ram_init_fsm
`default_nettype wire

// File: rtl/px_ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module      : px_ram_sp_be
// Description : Single-port RAM with byte-lane write enables, 1- or 2-cycle
//               registered read, selectable read-during-write behaviour and
//               a self-clearing init sweep after reset.
//               Optional feature macro PX_RAM_SP_BE_PARITY_EN adds one even
//               parity bit per lane and the parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module px_ram_sp_be
    import px_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             wen,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] ben,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             init_done
`ifdef PX_RAM_SP_BE_PARITY_EN
    ,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] parity_err
`endif
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef PX_RAM_SP_BE_PARITY_EN
    // Payload carried down the read pipe: {lane parity, data}
    localparam int PW    = DATA_WIDTH + NB;
`else
    localparam int PW    = DATA_WIDTH;
`endif

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_lanes
        $error("px_ram_sp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_chk_lat
        $error("px_ram_sp_be: RD_LATENCY must be 1 or 2");
    end
    if ((RDW_MODE != RDW_NO_CHANGE) && (RDW_MODE != RDW_WRITE_FIRST) &&
        (RDW_MODE != RDW_READ_FIRST)) begin : g_chk_rdw
        $error("px_ram_sp_be: RDW_MODE must be 0, 1 or 2");
    end

    // ------------------------------------------------------------------
    // Init sweep
    // ------------------------------------------------------------------
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  init_done_w;

    px_ram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_done_o (init_done_w)
    );

    // ------------------------------------------------------------------
    // Storage and write port
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_wdata;

    // User accesses only count once the sweep is finished
    assign w_wr    = init_done_w & ena & wen;
    assign w_rd    = init_done_w & ena & ~wen;
    assign w_we    = init_we | w_wr;
    assign w_waddr = init_we ? init_addr : addr;
    assign w_old   = mem_q[addr];
    assign w_wdata = init_we ? '0 : w_merged;

`ifdef PX_RAM_SP_BE_PARITY_EN
    logic [NB-1:0] mem_par_q [DEPTH];
    logic [NB-1:0] w_old_par;
    logic [NB-1:0] w_new_par;
    logic [NB-1:0] w_merged_par;
    logic [NB-1:0] w_wpar;

    assign w_old_par = mem_par_q[addr];
    assign w_wpar    = init_we ? '0 : w_merged_par;
`endif

    // Per-lane merge of new data into the addressed word
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = ben[i] ? data_in[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                             : w_old[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef PX_RAM_SP_BE_PARITY_EN
        assign w_new_par[i]    = ^data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        assign w_merged_par[i] = ben[i] ? w_new_par[i] : w_old_par[i];
`endif
    end

    // Array write: sweep zeros during INIT, merged word for user writes
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr]     <= w_wdata;
`ifdef PX_RAM_SP_BE_PARITY_EN
            mem_par_q[w_waddr] <= w_wpar;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read return selection (reads and read-during-write)
    // ------------------------------------------------------------------
    logic                  w_ret;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic [PW-1:0]         w_ret_pl;
`ifdef PX_RAM_SP_BE_PARITY_EN
    logic [NB-1:0]         w_ret_par;
`endif

    // Decide whether this access returns a word, and which version of it
    always_comb begin
        w_ret      = w_rd;
        w_ret_data = w_old;
`ifdef PX_RAM_SP_BE_PARITY_EN
        w_ret_par  = w_old_par;
`endif
        if (w_wr) begin
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                w_ret      = 1'b1;
                w_ret_data = w_merged;
`ifdef PX_RAM_SP_BE_PARITY_EN
                w_ret_par  = w_merged_par;
`endif
            end else if (RDW_MODE == RDW_READ_FIRST) begin
                w_ret      = 1'b1;
            end
        end
    end

`ifdef PX_RAM_SP_BE_PARITY_EN
    assign w_ret_pl = {w_ret_par, w_ret_data};
`else
    assign w_ret_pl = w_ret_data;
`endif

    // ------------------------------------------------------------------
    // Optional extra pipeline stage
    // ------------------------------------------------------------------
    logic          w_out_vld;
    logic [PW-1:0] w_out_pl;

    if (RD_LATENCY == 2) begin : g_lat2
        logic          s1_vld_q;
        logic [PW-1:0] s1_pl_q;

        // First read stage; cleared on reset so in-flight reads vanish
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld_q <= 1'b0;
                s1_pl_q  <= '0;
            end else begin
                s1_vld_q <= w_ret;
                if (w_ret) begin
                    s1_pl_q <= w_ret_pl;
                end
            end
        end

        assign w_out_vld = s1_vld_q;
        assign w_out_pl  = s1_pl_q;
    end else begin : g_lat1
        assign w_out_vld = w_ret;
        assign w_out_pl  = w_ret_pl;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    // data_out only moves when a new word arrives, otherwise it holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_out_vld;
            if (w_out_vld) begin
                data_out_q <= w_out_pl[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef PX_RAM_SP_BE_PARITY_EN
    logic [NB-1:0] w_par_chk;
    logic [NB-1:0] parity_err_q;

    // Even parity: a lane is bad when data and stored bit XOR to 1
    for (genvar i = 0; i < NB; i++) begin : g_par_chk
        assign w_par_chk[i] = ^{w_out_pl[DATA_WIDTH+i], w_out_pl[i*BYTE_WIDTH +: BYTE_WIDTH]};
    end

    // Error flags pulse together with rd_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= '0;
        end else begin
            parity_err_q <= w_out_vld ? w_par_chk : '0;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_w;

endmodule : px_ram_sp_be
`default_nettype wire

// File: tb/tb_px_ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_px_ram_sp_be
// Description : Scoreboard bench for px_ram_sp_be. Three instances share one
//               stimulus stream: default (latency 1, NO_CHANGE), latency 2
//               WRITE_FIRST, and latency 1 READ_FIRST.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_px_ram_sp_be;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = 4;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          wen;
    logic [NB-1:0] ben;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;

    logic [DW-1:0] do0, do1, do2;
    logic          rv0, rv1, rv2;
    logic          id0, id1, id2;
`ifdef PX_RAM_SP_BE_PARITY_EN
    logic [NB-1:0] pe0, pe1, pe2;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] perr;
        int unsigned   cyc;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] last_exp [3];
    logic [DW-1:0] model_mem [16];
    int unsigned   cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    px_ram_sp_be dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wen(wen), .ben(ben), .addr(addr),
        .data_in(data_in), .data_out(do0), .rd_valid(rv0), .init_done(id0)
`ifdef PX_RAM_SP_BE_PARITY_EN
        , .parity_err(pe0)
`endif
    );

    px_ram_sp_be #(.RD_LATENCY(2), .RDW_MODE(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wen(wen), .ben(ben), .addr(addr),
        .data_in(data_in), .data_out(do1), .rd_valid(rv1), .init_done(id1)
`ifdef PX_RAM_SP_BE_PARITY_EN
        , .parity_err(pe1)
`endif
    );

    px_ram_sp_be #(.RD_LATENCY(1), .RDW_MODE(2)) dut_rf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wen(wen), .ben(ben), .addr(addr),
        .data_in(data_in), .data_out(do2), .rd_valid(rv2), .init_done(id2)
`ifdef PX_RAM_SP_BE_PARITY_EN
        , .parity_err(pe2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual 0x%08h required 0x%08h", name, idx, act, req);
        end
    endtask

    function automatic int lat(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    task automatic push(input int idx, input logic [DW-1:0] d, input logic [NB-1:0] pe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.cyc  = cyc + lat(idx);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor for one instance: pop on rd_valid, otherwise data_out must hold
    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d, input logic [NB-1:0] pe);
        exp_t e;
        bit   have = 1'b0;
        if (v === 1'b1) begin
            case (idx)
                0:       if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                check("unexpected_rd_valid", idx, {31'b0, v}, 32'h0);
            end else begin
                check("rd_data", idx, d, e.data);
                check("rd_latency_cycle", idx, cyc, e.cyc);
`ifdef PX_RAM_SP_BE_PARITY_EN
                check("parity_err", idx, {28'b0, pe}, {28'b0, e.perr});
`endif
                last_exp[idx] = e.data;
            end
        end else begin
            check("data_out_hold", idx, d, last_exp[idx]);
`ifdef PX_RAM_SP_BE_PARITY_EN
            check("parity_err_idle", idx, {28'b0, pe}, 32'h0);
`endif
        end
    endtask

`ifdef PX_RAM_SP_BE_PARITY_EN
    always @(negedge clk) begin
        mon(0, rv0, do0, pe0);
        mon(1, rv1, do1, pe1);
        mon(2, rv2, do2, pe2);
    end
`else
    always @(negedge clk) begin
        mon(0, rv0, do0, 4'h0);
        mon(1, rv1, do1, 4'h0);
        mon(2, rv2, do2, 4'h0);
    end
`endif

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic [NB-1:0] exp_pe);
        @(negedge clk);
        ena     = 1'b1;
        wen     = 1'b0;
        addr    = a;
        ben     = 4'hA;
        data_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) push(i, exp_d, exp_pe);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        logic [DW-1:0] old_w;
        logic [DW-1:0] mrg;
        @(negedge clk);
        ena     = 1'b1;
        wen     = 1'b1;
        addr    = a;
        ben     = b;
        data_in = d;
        old_w   = model_mem[a];
        for (int i = 0; i < NB; i++) begin
            mrg[i*8 +: 8] = b[i] ? d[i*8 +: 8] : old_w[i*8 +: 8];
        end
        push(1, mrg, 4'h0);
        push(2, old_w, 4'h0);
        model_mem[a] = mrg;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ena = 1'b0;
            wen = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        idle(1);
        while (((q0.size() + q1.size() + q2.size()) != 0) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        check("queues_drained", -1, q0.size() + q1.size() + q2.size(), 32'h0);
    endtask

    task automatic chk_reset();
        check("rst_rd_valid", 0, {31'b0, rv0}, 32'h0);
        check("rst_rd_valid", 1, {31'b0, rv1}, 32'h0);
        check("rst_rd_valid", 2, {31'b0, rv2}, 32'h0);
        check("rst_data_out", 0, do0, 32'h0);
        check("rst_data_out", 1, do1, 32'h0);
        check("rst_init_done", 0, {31'b0, id0}, 32'h0);
        check("rst_init_done", 1, {31'b0, id1}, 32'h0);
        check("rst_init_done", 2, {31'b0, id2}, 32'h0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
    endtask

    // Release reset here and watch the 16-cycle sweep; ena is kept busy
    // with writes/reads to addr 0 that must all be ignored
    task automatic init_phase();
        rst_n   = 1'b1;
        ena     = 1'b1;
        wen     = 1'b1;
        addr    = 4'h0;
        ben     = 4'hF;
        data_in = 32'hDEAD_BEEF;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("init_done_timing", 0, {31'b0, id0}, {31'b0, (i == 16)});
            check("init_done_timing", 1, {31'b0, id1}, {31'b0, (i == 16)});
            check("init_done_timing", 2, {31'b0, id2}, {31'b0, (i == 16)});
            wen = ~wen;
        end
        ena = 1'b0;
        wen = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b0;
        wen     = 1'b0;
        ben     = '0;
        addr    = '0;
        data_in = '0;
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk_reset();

        // Reset in the middle of the sweep (cnt = 7), then full sweep
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        assert_reset();
        #1;
        chk_reset();
        @(negedge clk);
        init_phase();

        // Cleared array, including the address poked during INIT
        do_read(4'hF, 32'h0000_0000, 4'h0);
        do_read(4'h0, 32'h0000_0000, 4'h0);

        // Byte enables
        do_write(4'h3, 32'hAABB_CCDD, 4'hF);
        do_write(4'h3, 32'h1122_3344, 4'h5);
        do_read(4'h3, 32'hAA22_CC44, 4'h0);
        do_write(4'h3, 32'hFFFF_FFFF, 4'h0);
        do_read(4'h3, 32'hAA22_CC44, 4'h0);

        // Read immediately after a write to the same address
        do_write(4'h4, 32'hCAFE_F00D, 4'hF);
        do_read(4'h4, 32'hCAFE_F00D, 4'h0);

        // Read-during-write on a cleared word
        do_write(4'h5, 32'h1234_5678, 4'hF);
        idle(3);
        do_read(4'h5, 32'h1234_5678, 4'h0);

        // Back-to-back reads
        do_write(4'h1, 32'h1111_1111, 4'hF);
        do_write(4'h2, 32'h2222_2222, 4'hF);
        do_read(4'h1, 32'h1111_1111, 4'h0);
        do_read(4'h2, 32'h2222_2222, 4'h0);
        do_read(4'h3, 32'hAA22_CC44, 4'h0);
        drain();

        // Reset with a read in flight in the latency-2 instance
        do_read(4'h4, 32'hCAFE_F00D, 4'h0);
        @(negedge clk);
        ena = 1'b0;
        #1;
        assert_reset();
        #1;
        chk_reset();
        repeat (2) @(negedge clk);
        init_phase();
        do_read(4'h3, 32'h0000_0000, 4'h0);
        drain();

`ifdef PX_RAM_SP_BE_PARITY_EN
        // Corrupt the stored lane-2 parity bit of addr 9
        dut.mem_par_q[9][2]    = ~dut.mem_par_q[9][2];
        dut_wf.mem_par_q[9][2] = ~dut_wf.mem_par_q[9][2];
        dut_rf.mem_par_q[9][2] = ~dut_rf.mem_par_q[9][2];
        do_read(4'h9, 32'h0000_0000, 4'h4);
        do_read(4'h3, 32'h0000_0000, 4'h0);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_px_ram_sp_be
`default_nettype wire

// File: doc/px_ram_sp_be.md
PX_RAM_SP_BE -- requirements
Module: px_ram_sp_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be an integer multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 SHALL have parameter RD_LATENCY, default 1: read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter RDW_MODE, default 0: write-port read behaviour; 0 = NO_CHANGE, 1 = WRITE_FIRST, 2 = READ_FIRST.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ena, input, 1 bit: access enable.
REQ-009 SHALL have port wen, input, 1 bit: 1 = write, 0 = read (qualified by ena).
REQ-010 SHALL have port ben, input, NB bits: byte-lane write enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-011 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-012 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port data_out, output, DATA_WIDTH bits: read data (registered).
REQ-014 SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking new data_out.
REQ-015 SHALL have port init_done, output, 1 bit: 1 once the array has been cleared after reset.

Function
REQ-016 SHALL hold an init FSM with states INIT and IDLE; INIT writes zero to address cnt, incrementing cnt from 0 to DEPTH-1, one word per cycle.
REQ-017 SHALL transition INIT->IDLE on the cycle after the DEPTH-1 write; init_done is 1 exactly in IDLE, so it rises DEPTH cycles after rst_n deasserts.
REQ-018 SHALL ignore ena during INIT: no array write, no rd_valid.
REQ-019 SHALL, in IDLE with ena=1 and wen=1, update only the lanes with ben[i]=1 at the next edge; ben=0 is a legal no-op write.
REQ-020 SHALL, in IDLE with ena=1 and wen=0, present mem[addr] on data_out with rd_valid=1 exactly RD_LATENCY cycles after the request edge; ben is ignored.
REQ-021 SHALL pipeline reads fully: back-to-back reads produce back-to-back rd_valid pulses in request order.
REQ-022 SHALL, on writes, behave per RDW_MODE. NO_CHANGE: no rd_valid, data_out unchanged. WRITE_FIRST: return the merged new word with rd_valid. READ_FIRST: return the pre-write word with rd_valid. Latency is RD_LATENCY in every mode.
REQ-023 SHALL hold data_out between rd_valid pulses.
REQ-024 SHALL make a read in the cycle after a write to the same address return the written data (no stale hazard).

Reset
REQ-025 SHALL, on rst_n=0, immediately clear data_out, rd_valid, init_done, cnt and the read pipeline, and force state INIT.
REQ-026 SHALL leave the array contents unreset; clearing is done only by the INIT sweep.
REQ-027 SHALL, on reset asserted mid-INIT or mid-read, abandon the sweep or read and restart the sweep at address 0, with no rd_valid emitted for reads in flight.

Configuration
REQ-028 SHALL, with macro PX_RAM_SP_BE_PARITY_EN defined, store one even-parity bit per lane.
REQ-029 SHALL, with PX_RAM_SP_BE_PARITY_EN defined, add output port parity_err [NB-1:0], which is 0 at reset and pulses aligned with rd_valid for each lane whose parity check fails.
REQ-030 SHALL, with PX_RAM_SP_BE_PARITY_EN defined, write zero parity during INIT.
REQ-031 SHALL, without PX_RAM_SP_BE_PARITY_EN, have no parity storage and no parity_err port.

Structure
REQ-032 SHALL take the RDW_MODE encodings (NO_CHANGE/WRITE_FIRST/READ_FIRST) and the FSM state encodings from shared package px_ram_pkg.
REQ-033 SHALL implement the init sweep (FSM, cnt, init_done) in sub-module px_ram_init_fsm.
REQ-034 SHALL check parameter legality (DATA_WIDTH % BYTE_WIDTH == 0, RD_LATENCY in {1,2}, RDW_MODE in {0,1,2}) at elaboration.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, BYTE_WIDTH=8)
REQ-035 SHALL cover init: release rst_n; init_done=0 for 16 cycles, then 1; a read of addr 0xF then returns 0x00000000.
REQ-036 SHALL cover byte enables: write 0xAABBCCDD with ben=0xF, then 0x11223344 with ben=0x5 to addr 3; read addr 3 -> 0xAA22CC44; with RD_LATENCY=2, rd_valid arrives 2 cycles after the request.
REQ-037 SHALL cover RDW modes: addr 5 holds 0x0, write 0x12345678 with ben=0xF. WRITE_FIRST -> data_out=0x12345678 with rd_valid. READ_FIRST -> 0x0 with rd_valid. NO_CHANGE -> no rd_valid, data_out held.
REQ-038 SHALL cover back-to-back reads: read addrs 1,2,3 on consecutive cycles -> three consecutive rd_valid pulses with the matching data, in order.
REQ-039 SHALL cover reset: assert rst_n at cnt=7 of INIT, and separately with a read in flight; the sweep restarts at 0, init_done falls, and no rd_valid is emitted.
REQ-040 SHALL cover parity (PX_RAM_SP_BE_PARITY_EN defined): force-flip the stored lane-2 bit of addr 9 and read addr 9 -> parity_err=0x4 aligned with rd_valid.
